btn_debounce_pulse: RTL and testbench
=====================================

# btn_debounce_pulse

Push-button conditioning block that consumes the divided debounce clock produced by the system frequency divider. It debounces up to N_BTN raw push-button inputs by sampling them on each rising edge of clk_debounce, and emits debounced levels plus single-`clk`-cycle press and release pulses. It optionally emits auto-repeat pulses while a button is held. Outputs feed the FSM/control logic that drives the 14-segment display.

## Interface
- N_BTN, 4: number of buttons.
- DB_DEPTH, 4: consecutive identical samples (debounce ticks) required to change a level; ≥2.
- LONG_TICKS, 32: ticks from press to first repeat pulse; ≥2.
- REPEAT_TICKS, 8: ticks between subsequent repeat pulses; ≥2.

- clk  in  1  system clock (~40 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- clk_debounce  in  1  divided debounce clock; registered in the `clk` domain, used only as data (never as a clock).
- btn_raw  in  N_BTN  raw asynchronous button inputs, active-high.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-`clk` pulse on debounced 0→1.
- btn_release  out  N_BTN  one-`clk` pulse on debounced 1→0.
- btn_repeat  out  N_BTN  one-`clk` auto-repeat pulse (BTN_REPEAT_EN only).

## Operation
- Synchroniser: btn_raw passes through 2 flops per bit, giving btn_sync.
- Tick: the previous clk_debounce is registered. tick = clk_debounce & ~prev. tick is high for exactly one `clk` cycle per divided period.
- Shift register: each button has a DB_DEPTH-bit shift register. On a tick, btn_sync shifts in at the LSB. Between ticks the register holds.
- Level update:
  - When the shift result (including the bit shifted in this tick) is all ones, btn_level becomes 1.
  - When it is all zeros, btn_level becomes 0.
  - Otherwise btn_level holds.
- Pulses: btn_press = level rises this update; btn_release = level falls this update. Both last exactly one cycle and are never asserted together for the same bit.
- Buttons are fully independent. Several bits may pulse in the same cycle.
- Repeat FSM, per button (BTN_REPEAT_EN):
  - IDLE: on a press, go to HELD with cnt=0.
  - HELD: on each tick, cnt++. On the tick where cnt==LONG_TICKS-1, pulse btn_repeat, set cnt=0, and go to REPEAT.
  - REPEAT: on the tick where cnt==REPEAT_TICKS-1, pulse btn_repeat and set cnt=0. On other ticks, cnt++.
  - Any state: a release returns the FSM to IDLE with cnt=0. A release and a repeat in the same tick means release wins and no repeat pulse is issued.
- cnt width is $clog2(max(LONG_TICKS, REPEAT_TICKS)) and never wraps past its terminal value.

## Timing
- Reset (asynchronous): synchroniser, prev, shift registers, btn_level, btn_press, btn_release, btn_repeat, FSMs (IDLE) and cnt all go to 0. A button held through reset produces a press once DB_DEPTH ones have been sampled after reset. No release pulse is generated for a press that was interrupted by reset.
- Tick cycle T is the cycle in which clk_debounce=1 and prev=0. Shift, level, pulse and FSM updates are registered at the end of T and visible in T+1.
- Latency from a stable raw edge to btn_press/btn_release: 2 `clk` (sync) plus up to DB_DEPTH ticks, plus 1 `clk`.
- Glitch rejection: any raw pulse or dropout shorter than DB_DEPTH consecutive samples produces no level change.
- First btn_repeat is exactly LONG_TICKS ticks after the btn_press tick. Later repeats follow every REPEAT_TICKS ticks.
- clk_debounce held constant gives no ticks, and all state freezes.

## Configuration
- BTN_REPEAT_EN defined: the repeat FSM and counters are built, and btn_repeat behaves as above.
- BTN_REPEAT_EN undefined: there are no FSM or counters, and btn_repeat is tied to 0. The port is still present. btn_level, btn_press and btn_release are unchanged.

## Test plan
- Reset: assert rst_n=0 mid-operation with btn_raw=4'hF. All outputs are 0 immediately (asynchronously) and stay 0 while in reset.
- Glitch: with default parameters, raise btn_raw[0] for 2 ticks and then drop it. btn_level=0 and no btn_press.
- Press/release: hold btn_raw[1]=1 for 4 ticks. btn_level[1]=1 and btn_press[1] is high for exactly 1 cycle, one cycle after the 4th tick. Drop it for 4 ticks, giving one btn_release[1] pulse.
- Simultaneous: raise btn_raw[0] and btn_raw[3] together. Both press pulses occur in the same cycle, and btn_press=4'b1001.
- Repeat (BTN_REPEAT_EN): hold btn_raw[2] for 4+32+24 ticks. btn_repeat[2] pulses 32 ticks after btn_press[2], then 8 and 16 ticks later (3 pulses total). Release on the tick a repeat is due produces no repeat, only btn_release[2].
- Reset mid-hold: press bit 0, then pulse rst_n low while holding. Release after re-press produces exactly one press and one release pulse, and no spurious release.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: sync, tick-sampled shift-register debounce, press/release pulses.
// Optional per-button auto-repeat generator is built when BTN_REPEAT_EN is defined.
module btn_debounce_pulse #(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned DB_DEPTH     = 4,
   parameter int unsigned LONG_TICKS   = 32,
   parameter int unsigned REPEAT_TICKS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_debounce,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   // Elaboration-time parameter sanity checks
   if (N_BTN < 1)        $error("N_BTN must be at least 1");
   if (DB_DEPTH < 2)     $error("DB_DEPTH must be at least 2");
   if (LONG_TICKS < 2)   $error("LONG_TICKS must be at least 2");
   if (REPEAT_TICKS < 2) $error("REPEAT_TICKS must be at least 2");

   logic [N_BTN-1:0]                sync_q1;
   logic [N_BTN-1:0]                btn_sync;
   logic                            db_prev;
   logic                            tick_c;
   logic [N_BTN-1:0][DB_DEPTH-1:0]  shreg;
   logic [N_BTN-1:0][DB_DEPTH-1:0]  shift_c;
   logic [N_BTN-1:0]                press_c;
   logic [N_BTN-1:0]                release_c;

   // Two-flop synchroniser for the raw buttons and edge history of the debounce clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1  <= '0;
         btn_sync <= '0;
         db_prev  <= 1'b0;
      end else begin
         sync_q1  <= btn_raw;
         btn_sync <= sync_q1;
         db_prev  <= clk_debounce;
      end
   end

   assign tick_c = clk_debounce & ~db_prev;

   // Candidate shift result and level-change events for this tick
   always_comb begin
      shift_c   = shreg;
      press_c   = '0;
      release_c = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         shift_c[i]   = {shreg[i][DB_DEPTH-2:0], btn_sync[i]};
         press_c[i]   = tick_c & ~btn_level[i] & (&shift_c[i]);
         release_c[i] = tick_c &  btn_level[i] & ~(|shift_c[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg       <= '0;
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
      end else begin
         btn_press   <= press_c;
         btn_release <= release_c;
         if (tick_c) begin
            shreg <= shift_c;
         end
         btn_level <= (btn_level | press_c) & ~release_c;
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int unsigned MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int unsigned CNT_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HELD   = 2'd1,
      S_REPEAT = 2'd2
   } rpt_state_e;

   rpt_state_e                   state_q [N_BTN];
   rpt_state_e                   state_d [N_BTN];
   logic [N_BTN-1:0][CNT_W-1:0]  cnt_q;
   logic [N_BTN-1:0][CNT_W-1:0]  cnt_d;
   logic [N_BTN-1:0]             repeat_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            state_q[i] <= S_IDLE;
         end
         cnt_q      <= '0;
         btn_repeat <= '0;
      end else begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            state_q[i] <= state_d[i];
         end
         cnt_q      <= cnt_d;
         btn_repeat <= repeat_c;
      end
   end

   // Release has priority over any repeat falling due on the same tick
   always_comb begin
      cnt_d    = cnt_q;
      repeat_c = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         state_d[i] = state_q[i];
         if (release_c[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               S_IDLE: begin
                  if (press_c[i]) begin
                     state_d[i] = S_HELD;
                     cnt_d[i]   = '0;
                  end
               end
               S_HELD: begin
                  if (tick_c) begin
                     if (cnt_q[i] == CNT_W'(LONG_TICKS - 1)) begin
                        repeat_c[i] = 1'b1;
                        cnt_d[i]    = '0;
                        state_d[i]  = S_REPEAT;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                     end
                  end
               end
               S_REPEAT: begin
                  if (tick_c) begin
                     if (cnt_q[i] == CNT_W'(REPEAT_TICKS - 1)) begin
                        repeat_c[i] = 1'b1;
                        cnt_d[i]    = '0;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end
`else
   assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: pulse scoreboard plus direct level/pulse checks.
module tb_btn_debounce_pulse;

`ifdef BTN_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_debounce = 1'b0;
   logic [3:0] btn_raw = 4'h0;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [3:0] btn_repeat;

   int total = 0;
   int bad   = 0;

   // Expected pulse events {press, release, repeat}
   logic [11:0] sb [$];

   always #5 clk = ~clk;

   btn_debounce_pulse #(
      .N_BTN        (4),
      .DB_DEPTH     (4),
      .LONG_TICKS   (32),
      .REPEAT_TICKS (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_debounce (clk_debounce),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_press    (btn_press),
      .btn_release  (btn_release),
      .btn_repeat   (btn_repeat)
   );

   // Every nonzero pulse vector must match the next scoreboard entry
   always @(negedge clk) begin
      logic [11:0] obs;
      logic [11:0] exp;
      obs = {btn_press, btn_release, btn_repeat};
      if (rst_n && obs != 12'h000) begin
         total++;
         exp = (sb.size() == 0) ? 12'h000 : sb.pop_front();
         assert (obs === exp) else begin
            bad++;
            $error("FAIL pulse_sb observed=%h expected=%h", obs, exp);
         end
      end
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] p, input logic [3:0] r, input logic [3:0] rp);
      sb.push_back({p, r, rp});
   endtask

   // One debounce tick: low for 3 clk (lets the synchroniser settle), high for 1 clk
   task automatic tick();
      repeat (3) @(posedge clk);
      #1 clk_debounce = 1'b1;
      @(posedge clk);
      #1 clk_debounce = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [3:0] exp_rep;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_level", btn_level, 4'h0);
      check("rst_press", btn_press, 4'h0);
      check("rst_release", btn_release, 4'h0);
      check("rst_repeat", btn_repeat, 4'h0);
      rst_n = 1'b1;

      // Asynchronous reset while all buttons are held
      btn_raw = 4'hF;
      ticks(3);
      push(4'hF, 4'h0, 4'h0);
      tick();
      @(negedge clk);
      check("press_all", btn_press, 4'hF);
      check("level_all", btn_level, 4'hF);
      ticks(2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_level", btn_level, 4'h0);
      check("async_press", btn_press, 4'h0);
      check("async_release", btn_release, 4'h0);
      check("async_repeat", btn_repeat, 4'h0);
      ticks(2);
      @(negedge clk);
      check("inrst_level", btn_level, 4'h0);
      check("inrst_release", btn_release, 4'h0);
      btn_raw = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;

      // Glitch shorter than DB_DEPTH samples
      btn_raw = 4'h1;
      ticks(2);
      btn_raw = 4'h0;
      ticks(4);
      @(negedge clk);
      check("glitch_level", btn_level, 4'h0);

      // Single press / release on bit 1
      btn_raw = 4'h2;
      ticks(3);
      @(negedge clk);
      check("pre_press_level", btn_level, 4'h0);
      push(4'h2, 4'h0, 4'h0);
      tick();
      @(negedge clk);
      check("press1", btn_press, 4'h2);
      check("level1", btn_level, 4'h2);
      @(negedge clk);
      check("press1_width", btn_press, 4'h0);
      btn_raw = 4'h0;
      ticks(3);
      @(negedge clk);
      check("pre_release_level", btn_level, 4'h2);
      push(4'h0, 4'h2, 4'h0);
      tick();
      @(negedge clk);
      check("release1", btn_release, 4'h2);
      check("level1_off", btn_level, 4'h0);
      @(negedge clk);
      check("release1_width", btn_release, 4'h0);

      // Simultaneous bits 0 and 3
      btn_raw = 4'h9;
      ticks(3);
      push(4'h9, 4'h0, 4'h0);
      tick();
      @(negedge clk);
      check("press_sim", btn_press, 4'h9);
      btn_raw = 4'h0;
      ticks(3);
      push(4'h0, 4'h9, 4'h0);
      tick();
      @(negedge clk);
      check("release_sim", btn_release, 4'h9);

      // No ticks: state frozen
      btn_raw = 4'hF;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("freeze_level", btn_level, 4'h0);
      btn_raw = 4'h0;
      repeat (5) @(posedge clk);

      // Auto-repeat on bit 2; release lands on the tick a repeat falls due
      btn_raw = 4'h4;
      ticks(3);
      push(4'h4, 4'h0, 4'h0);
      tick();
      @(negedge clk);
      check("press2", btn_press, 4'h4);
      for (int k = 1; k <= 56; k++) begin
         btn_raw = (k <= 52) ? 4'h4 : 4'h0;
         exp_rep = (RPT_EN && (k == 32 || k == 40 || k == 48)) ? 4'h4 : 4'h0;
         if (exp_rep != 4'h0) push(4'h0, 4'h0, exp_rep);
         if (k == 56) push(4'h0, 4'h4, 4'h0);
         tick();
         @(negedge clk);
         check($sformatf("repeat_k%0d", k), btn_repeat, exp_rep);
         if (k == 56) check("release2", btn_release, 4'h4);
      end

      // Reset while bit 0 is held, then re-press and release
      btn_raw = 4'h1;
      ticks(3);
      push(4'h1, 4'h0, 4'h0);
      tick();
      @(negedge clk);
      check("press0", btn_press, 4'h1);
      ticks(2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midhold_level", btn_level, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(3);
      @(negedge clk);
      check("repress_wait", btn_level, 4'h0);
      push(4'h1, 4'h0, 4'h0);
      tick();
      @(negedge clk);
      check("repress0", btn_press, 4'h1);
      btn_raw = 4'h0;
      ticks(3);
      push(4'h0, 4'h1, 4'h0);
      tick();
      @(negedge clk);
      check("release0", btn_release, 4'h1);
      check("level0_off", btn_level, 4'h0);

      repeat (10) @(posedge clk);
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
